// File: rtl/rate_ctrl_pkg.sv
// rate_ctrl_pkg: controller states, divider width and default periods
package rate_ctrl_pkg;
  localparam int DIV_W = 27;
  localparam int DEF_PERIOD0 = 1;
  localparam int DEF_PERIOD1 = 25000000;
  localparam int DEF_PERIOD2 = 50000000;
  localparam int DEF_PERIOD3 = 100000000;
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
  function automatic logic [DIV_W-1:0] pick_period(input logic [1:0] sel, input logic [DIV_W-1:0] p0, p1, p2, p3);
    return sel[1] ? (sel[0] ? p3 : p2) : (sel[0] ? p1 : p0);
  endfunction
endpackage

// File: rtl/rate_divider.sv
// rate_divider: down-counter that reloads period-1 and flags zero
module rate_divider
  import rate_ctrl_pkg::*;
(
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic [DIV_W-1:0] period,
  input  logic             reload,
  input  logic             enable,
  output logic             zero,
  output logic [DIV_W-1:0] value
);
  assign zero = value == '0;
  always_ff @(posedge CLOCK_50 or posedge reset)
    if (reset) value <= '0;
    else if (reload) value <= period - DIV_W'(1);
    else if (enable) value <= value - DIV_W'(1);
endmodule

// File: rtl/rate_count_ctrl.sv
// rate_count_ctrl: start/stop/pause hex counter stepping once per selected divider period
module rate_count_ctrl
  import rate_ctrl_pkg::*;
#(
  parameter int PERIOD0 = DEF_PERIOD0,
  parameter int PERIOD1 = DEF_PERIOD1,
  parameter int PERIOD2 = DEF_PERIOD2,
  parameter int PERIOD3 = DEF_PERIOD3
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [1:0] rate_sel,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dir,
  output logic [3:0] count,
  output logic       tick,
  output logic       wrap,
  output logic       running
);
  state_t state, state_nx;
  logic ld, sp, st, adv, fire, div_zero;
  logic [DIV_W-1:0] div_val, div_period;
  // adv marks edges that consume one divider cycle: a stop edge does not, a resume edge does
  always_comb begin
    ld = load & ~clear;
    sp = stop & ~clear & ~load;
    st = start & ~clear & ~load & ~stop;
    adv = (state == RUN && !clear && !sp) || (state == PAUSE && st);
    fire = adv & div_zero;
    div_period = clear ? DIV_W'(1) : pick_period(rate_sel, DIV_W'(PERIOD0), DIV_W'(PERIOD1), DIV_W'(PERIOD2), DIV_W'(PERIOD3));
    state_nx = clear ? IDLE : (st && state != RUN) ? RUN : (sp && state == RUN) ? PAUSE : state;
  end
  rate_divider u_div (
    .CLOCK_50(CLOCK_50),
    .reset   (reset),
    .period  (div_period),
    .reload  (clear || (state == IDLE && st) || fire),
    .enable  (adv && div_val != '0),
    .zero    (div_zero),
    .value   (div_val)
  );
  assign running = state == RUN;
  always_ff @(posedge CLOCK_50 or posedge reset)
    if (reset) begin
      state <= IDLE;
      count <= '0;
      tick <= 1'b0;
      wrap <= 1'b0;
    end else begin
      state <= state_nx;
      tick <= fire;
      wrap <= fire & (dir ? &count : ~|count);
      count <= clear ? 4'd0 : (ld && state != RUN) ? load_val : fire ? (dir ? count + 4'd1 : count - 4'd1) : count;
    end
endmodule

// File: tb/tb_rate_count_ctrl.sv
// tb_rate_count_ctrl: vector table with scoreboard plus asynchronous reset sequences
module tb_rate_count_ctrl;
  logic CLOCK_50 = 1'b0, reset = 1'b1;
  logic [1:0] rate_sel = '0;
  logic start = 0, stop = 0, clear = 0, load = 0, dir = 1;
  logic [3:0] load_val = '0, count;
  logic tick, wrap, running;
  int passes = 0, total = 0;
  typedef struct packed {
    logic [1:0] rs;
    logic st, sp, cl, ld;
    logic [3:0] lv;
    logic d;
    logic [3:0] cnt;
    logic tk, wr, run;
  } vec_t;
  vec_t vecs[$];
  logic [6:0] sb[$];

  rate_count_ctrl #(.PERIOD0(1), .PERIOD1(4), .PERIOD2(8), .PERIOD3(16)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .rate_sel(rate_sel), .start(start), .stop(stop),
    .clear(clear), .load(load), .load_val(load_val), .dir(dir),
    .count(count), .tick(tick), .wrap(wrap), .running(running)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got count=%h tick=%b wrap=%b running=%b, expected count=%h tick=%b wrap=%b running=%b",
                  name, act[6:3], act[2], act[1], act[0], exp[6:3], exp[2], exp[1], exp[0]);
  endtask

  task automatic add(input logic [1:0] rs, input logic st, sp, cl, ld, input logic [3:0] lv, input logic d,
                     input logic [3:0] c, input logic t, w, r);
    vec_t v;
    v = '{rs, st, sp, cl, ld, lv, d, c, t, w, r};
    vecs.push_back(v);
  endtask

  task automatic hold(input int n, input logic [1:0] rs, input logic d, input logic [3:0] c, input logic r);
    repeat (n) add(rs, 0, 0, 0, 0, 4'h0, d, c, 0, 0, r);
  endtask

  task automatic run_vecs(input string tag);
    vec_t v;
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      @(negedge CLOCK_50);
      rate_sel = v.rs; start = v.st; stop = v.sp; clear = v.cl; load = v.ld; load_val = v.lv; dir = v.d;
      sb.push_back({v.cnt, v.tk, v.wr, v.run});
      @(posedge CLOCK_50);
      #1 check($sformatf("%s[%0d]", tag, i), {count, tick, wrap, running}, sb.pop_front());
    end
    vecs.delete();
  endtask

  // entered just after a clock edge; reset rises and falls before the next edge
  task automatic async_reset(input string tag);
    #2 reset = 1'b1;
    #1 check(tag, {count, tick, wrap, running}, 7'd0);
    reset = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge CLOCK_50);
    #1 check("reset", {count, tick, wrap, running}, 7'd0);
    reset = 1'b0;
    // steady ticks at period 4, load/start ignored while running, stop ignored in IDLE
    add(1, 1, 0, 0, 0, 4'h0, 1, 4'h0, 0, 0, 1);
    hold(3, 1, 1, 4'h0, 1);
    add(1, 0, 0, 0, 0, 4'h0, 1, 4'h1, 1, 0, 1);
    add(1, 0, 0, 0, 1, 4'h9, 1, 4'h1, 0, 0, 1);
    add(1, 1, 0, 0, 0, 4'h0, 1, 4'h1, 0, 0, 1);
    hold(1, 1, 1, 4'h1, 1);
    add(1, 0, 0, 0, 0, 4'h0, 1, 4'h2, 1, 0, 1);
    hold(3, 1, 1, 4'h2, 1);
    add(1, 0, 0, 0, 0, 4'h0, 1, 4'h3, 1, 0, 1);
    add(1, 0, 0, 1, 0, 4'h0, 1, 4'h0, 0, 0, 0);
    add(1, 0, 1, 0, 0, 4'h0, 1, 4'h0, 0, 0, 0);
    // wrap up from F and down from 0 at period 1; load beats start
    add(0, 1, 0, 0, 1, 4'hF, 1, 4'hF, 0, 0, 0);
    add(0, 1, 0, 0, 0, 4'h0, 1, 4'hF, 0, 0, 1);
    add(0, 0, 0, 0, 0, 4'h0, 1, 4'h0, 1, 1, 1);
    add(0, 0, 0, 1, 0, 4'h0, 1, 4'h0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 4'h0, 0, 4'h0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 4'h0, 0, 4'h0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 4'h0, 0, 4'hF, 1, 1, 1);
    add(0, 0, 0, 0, 0, 4'h0, 0, 4'hE, 1, 0, 1);
    add(0, 0, 0, 1, 0, 4'h0, 0, 4'h0, 0, 0, 0);
    // rate change mid-period applies only at the next reload
    add(1, 1, 0, 0, 0, 4'h0, 1, 4'h0, 0, 0, 1);
    hold(1, 1, 1, 4'h0, 1);
    hold(2, 3, 1, 4'h0, 1);
    add(3, 0, 0, 0, 0, 4'h0, 1, 4'h1, 1, 0, 1);
    hold(15, 3, 1, 4'h1, 1);
    add(3, 0, 0, 0, 0, 4'h0, 1, 4'h2, 1, 0, 1);
    add(3, 0, 0, 1, 0, 4'h0, 1, 4'h0, 0, 0, 0);
    // pause keeps remaining period; load in pause; stop on the zero cycle
    add(1, 1, 0, 0, 0, 4'h0, 1, 4'h0, 0, 0, 1);
    hold(1, 1, 1, 4'h0, 1);
    add(1, 0, 1, 0, 0, 4'h0, 1, 4'h0, 0, 0, 0);
    hold(9, 1, 1, 4'h0, 0);
    add(1, 1, 0, 0, 0, 4'h0, 1, 4'h0, 0, 0, 1);
    hold(1, 1, 1, 4'h0, 1);
    add(1, 0, 0, 0, 0, 4'h0, 1, 4'h1, 1, 0, 1);
    add(1, 0, 1, 0, 0, 4'h0, 1, 4'h1, 0, 0, 0);
    add(1, 0, 0, 0, 1, 4'h7, 1, 4'h7, 0, 0, 0);
    hold(3, 1, 1, 4'h7, 0);
    add(1, 1, 0, 0, 0, 4'h0, 1, 4'h7, 0, 0, 1);
    hold(2, 1, 1, 4'h7, 1);
    add(1, 0, 1, 0, 0, 4'h0, 1, 4'h7, 0, 0, 0);
    hold(2, 1, 1, 4'h7, 0);
    add(1, 1, 0, 0, 0, 4'h0, 1, 4'h8, 1, 0, 1);
    add(1, 0, 0, 1, 0, 4'h0, 1, 4'h0, 0, 0, 0);
    // clear together with start while running
    add(1, 1, 0, 0, 0, 4'h0, 1, 4'h0, 0, 0, 1);
    hold(3, 1, 1, 4'h0, 1);
    add(1, 0, 0, 0, 0, 4'h0, 1, 4'h1, 1, 0, 1);
    hold(1, 1, 1, 4'h1, 1);
    add(1, 1, 0, 1, 0, 4'h0, 1, 4'h0, 0, 0, 0);
    hold(20, 1, 1, 4'h0, 0);
    // run up to a tick so reset lands while tick and count are non-zero
    add(1, 1, 0, 0, 0, 4'h0, 1, 4'h0, 0, 0, 1);
    hold(3, 1, 1, 4'h0, 1);
    add(1, 0, 0, 0, 0, 4'h0, 1, 4'h1, 1, 0, 1);
    run_vecs("seq");
    async_reset("mid_reset");
    hold(20, 1, 1, 4'h0, 0);
    add(1, 1, 0, 0, 0, 4'h0, 1, 4'h0, 0, 0, 1);
    hold(3, 1, 1, 4'h0, 1);
    add(1, 0, 0, 0, 0, 4'h0, 1, 4'h1, 1, 0, 1);
    run_vecs("after_reset");
    async_reset("reset2");
    add(1, 1, 0, 0, 0, 4'h0, 1, 4'h0, 0, 0, 1);
    hold(3, 1, 1, 4'h0, 1);
    add(1, 0, 0, 0, 0, 4'h0, 1, 4'h1, 1, 0, 1);
    run_vecs("first_edge");
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule

// File: doc/rate_count_ctrl.md
RATE_COUNT_CTRL -- requirements
Module: rate_count_ctrl

Interface
REQ-001 Parameter PERIOD0, default 1, divider period in clock cycles for rate_sel=00.
REQ-002 Parameter PERIOD1, default 25000000, divider period for rate_sel=01 (0.5 s at 50 MHz).
REQ-003 Parameter PERIOD2, default 50000000, divider period for rate_sel=10.
REQ-004 Parameter PERIOD3, default 100000000, divider period for rate_sel=11; all periods SHALL be 1..2^27-1.
REQ-005 CLOCK_50  in  1  sole clock; all state SHALL change on its rising edge only.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 rate_sel  in  2  divider period select.
REQ-008 start  in  1  single-cycle pulse: run or resume counting.
REQ-009 stop  in  1  single-cycle pulse: pause counting.
REQ-010 clear  in  1  single-cycle pulse: zero the count and return to IDLE.
REQ-011 load  in  1  single-cycle pulse: load load_val into count.
REQ-012 load_val  in  4  value for load.
REQ-013 dir  in  1  count direction, 1=up, 0=down.
REQ-014 count  out  4  current hex digit, registered, for the seg7 decoder.
REQ-015 tick  out  1  one-cycle pulse in the cycle count updates.
REQ-016 wrap  out  1  one-cycle pulse when count wraps (15->0 up, 0->15 down).
REQ-017 running  out  1  high exactly when state is RUN.

Function
REQ-018 The FSM SHALL have states IDLE, RUN and PAUSE.
REQ-019 Command priority SHALL be clear > load > stop > start; lower-priority commands in the same cycle are discarded.
REQ-020 IDLE: start->RUN; load->count=load_val, stay IDLE; stop ignored.
REQ-021 RUN: stop->PAUSE; clear->IDLE; load and start ignored.
REQ-022 PAUSE: start->RUN; clear->IDLE; load->count=load_val, stay PAUSE; divider value SHALL be held.
REQ-023 Divider: 27-bit down-counter; on IDLE->RUN it SHALL load P-1 (P = period selected by rate_sel that cycle).
REQ-024 In RUN, when divider=0: tick=1, divider reloads P-1 using the current rate_sel, count steps by dir; otherwise divider decrements.
REQ-025 First tick after start from IDLE SHALL occur exactly P cycles after the start cycle; subsequent ticks every P cycles.
REQ-026 rate_sel changes while running SHALL take effect only at the next reload; no truncated or extended period.
REQ-027 PAUSE->RUN SHALL resume from the held divider value; the interrupted period completes with its remaining cycles.
REQ-028 count arithmetic SHALL be modulo 16; wrap SHALL be asserted in the same cycle as the wrapping tick only.
REQ-029 stop in the same cycle the divider reaches 0 SHALL win: no tick, divider held at 0, and the tick fires on the first RUN cycle after resume.
REQ-030 clear SHALL set count=0 and divider=0, and deassert tick/wrap the next cycle.
REQ-031 dir SHALL be sampled at each tick; changing it never alters the period.

Reset
REQ-032 reset SHALL force state=IDLE, count=0, divider=0, tick=0, wrap=0, running=0 immediately, independent of CLOCK_50.
REQ-033 reset asserted mid-period SHALL discard the partial period; no tick SHALL be emitted on or after deassertion until a new start.
REQ-034 The first edge after reset deassertion SHALL honor commands normally.

Structure
REQ-035 State encodings and default period constants SHALL live in shared package rate_ctrl_pkg.
REQ-036 Divider SHALL be a separate sub-module rate_divider (inputs: period, reload, enable; outputs: zero, value); FSM and count register stay in rate_count_ctrl.
REQ-037 count SHALL connect directly to the existing 7-segment decoder without extra logic.

Verification (bench overrides PERIOD0..3 = 1, 4, 8, 16)
REQ-038 reset; rate_sel=01, dir=1, start at cycle 0 -> tick at cycles 4, 8, 12; count 1, 2, 3; running=1.
REQ-039 load_val=F in IDLE, dir=1, start, rate_sel=00 -> next tick count=0 with wrap=1; with dir=0 from load 0 -> count=F, wrap=1.
REQ-040 rate_sel=01 running, switch to 11 at cycle 2 -> next tick still at cycle 4, following at cycle 20.
REQ-041 stop at cycle 2 of a 4-cycle period, wait 10, start -> tick 2 cycles after resume; load during PAUSE=7 -> count=7, no tick.
REQ-042 clear and start in same cycle while RUN -> IDLE, count=0, running=0, no tick for 20 cycles.
REQ-043 reset asserted mid-period between clock edges -> outputs zero immediately; no tick for 20 cycles after deassertion.
